acc_bias_unit: RTL and testbench

Per-column accumulate-and-bias stage that drives the bound/clamp stage of the RELU_BOUND path. It sums ACC_LEN partial-sum beats per output for each of COLS columns, adds a per-column bias, saturates to AB_BW signed bits, and presents the packed result with a one-cycle valid pulse. Its output bus matches the bound stage's `i_acc_bias` input exactly: same COLS, same AB_BW, same packing.

---
 rtl/acc_bias_unit_if.sv | 37 +++
 rtl/acc_bias_unit.sv | 102 ++++++++++
 tb/tb_acc_bias_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/acc_bias_unit_if.sv
// rtl/acc_bias_unit_if.sv - partial-sum / bias / result bus of acc_bias_unit
//
// Purpose: groups the beat, clear, bias-load and result signals of
//   acc_bias_unit into one bundle.
// Signals:
//   i_valid    partial-sum beat present this cycle
//   i_psum     COLS signed PS_BW partial sums, column c at [(c+1)*PS_BW-1 -: PS_BW]
//   i_clear    synchronous abort of the current group
//   i_bias_we  load bias registers
//   i_bias     COLS signed BI_BW biases, column c at [(c+1)*BI_BW-1 -: BI_BW]
//   o_valid    one-cycle pulse, o_acc_bias holds a new result
//   o_acc_bias COLS signed AB_BW results, column c at [(c+1)*AB_BW-1 -: AB_BW]
// Modports: master drives the inputs (producer), slave is the accumulator.
interface acc_bias_unit_if #(
  parameter int COLS  = 5,
  parameter int PS_BW = 16,
  parameter int BI_BW = 8,
  parameter int AB_BW = 25
);
  logic                   i_valid;
  logic [PS_BW*COLS-1:0]  i_psum;
  logic                   i_clear;
  logic                   i_bias_we;
  logic [BI_BW*COLS-1:0]  i_bias;
  logic                   o_valid;
  logic [AB_BW*COLS-1:0]  o_acc_bias;

  modport master (
    output i_valid, i_psum, i_clear, i_bias_we, i_bias,
    input  o_valid, o_acc_bias
  );

  modport slave (
    input  i_valid, i_psum, i_clear, i_bias_we, i_bias,
    output o_valid, o_acc_bias
  );
endinterface

// File: rtl/acc_bias_unit.sv
// rtl/acc_bias_unit.sv - per-column accumulate, bias add and saturate stage
//
// Purpose: sums ACC_LEN partial-sum beats per column, adds a per-column bias,
//   saturates to AB_BW signed bits and presents the packed result with a
//   one-cycle valid pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    acc_bias_unit_if.slave (i_valid, i_psum, i_clear, i_bias_we,
//          i_bias in; o_valid, o_acc_bias out)
module acc_bias_unit #(
  parameter int COLS    = 5,
  parameter int PS_BW   = 16,
  parameter int BI_BW   = 8,
  parameter int AB_BW   = 25,
  parameter int ACC_LEN = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  acc_bias_unit_if.slave   bus
);

  localparam int            CW   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  // Clamp an AB_BW+1 bit sum back into AB_BW bits: overflow shows up as the
  // two top bits disagreeing, and the top bit gives the true sign.
  function automatic logic signed [AB_BW-1:0] f_sat(input logic signed [AB_BW:0] x);
    if (x[AB_BW] != x[AB_BW-1])
      f_sat = x[AB_BW] ? {1'b1, {(AB_BW-1){1'b0}}} : {1'b0, {(AB_BW-1){1'b1}}};
    else
      f_sat = x[AB_BW-1:0];
  endfunction

  logic [CW-1:0]            r_cnt;
  logic signed [AB_BW-1:0]  r_acc  [COLS];
  logic [BI_BW-1:0]         r_bias [COLS];
  logic                     r_valid;
  logic [AB_BW*COLS-1:0]    r_out;

  logic signed [AB_BW-1:0]  w_acc_nxt [COLS];
  logic signed [AB_BW-1:0]  w_res     [COLS];
  logic                     w_last;

  // A beat discarded by a concurrent clear never completes a group.
  assign w_last = bus.i_valid & ~bus.i_clear & (r_cnt == LAST);

  for (genvar g = 0; g < COLS; g++) begin : g_col
    logic [PS_BW-1:0]   w_ps;
    logic [AB_BW:0]     w_sum_ps;
    logic [AB_BW:0]     w_sum_bi;

    assign w_ps     = bus.i_psum[(g+1)*PS_BW-1 -: PS_BW];
    assign w_sum_ps = {r_acc[g][AB_BW-1], r_acc[g]}
                    + {{(AB_BW+1-PS_BW){w_ps[PS_BW-1]}}, w_ps};
    assign w_acc_nxt[g] = f_sat(w_sum_ps);
    // The bias is added to the already-saturated running sum, using the
    // bias register value before any same-cycle load.
    assign w_sum_bi = {w_acc_nxt[g][AB_BW-1], w_acc_nxt[g]}
                    + {{(AB_BW+1-BI_BW){r_bias[g][BI_BW-1]}}, r_bias[g]};
    assign w_res[g] = f_sat(w_sum_bi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
      for (int c = 0; c < COLS; c++) begin
        r_acc[c]  <= '0;
        r_bias[c] <= '0;
      end
    end else begin
      r_valid <= w_last;
      if (bus.i_bias_we) begin
        for (int c = 0; c < COLS; c++)
          r_bias[c] <= bus.i_bias[(c+1)*BI_BW-1 -: BI_BW];
      end
      if (bus.i_clear) begin
        r_cnt <= '0;
        for (int c = 0; c < COLS; c++)
          r_acc[c] <= '0;
      end else if (bus.i_valid) begin
        if (r_cnt == LAST) begin
          r_cnt <= '0;
          for (int c = 0; c < COLS; c++) begin
            r_acc[c]                         <= '0;
            r_out[(c+1)*AB_BW-1 -: AB_BW]    <= w_res[c];
          end
        end else begin
          r_cnt <= r_cnt + CW'(1);
          for (int c = 0; c < COLS; c++)
            r_acc[c] <= w_acc_nxt[c];
        end
      end
    end
  end

  assign bus.o_valid    = r_valid;
  assign bus.o_acc_bias = r_out;

endmodule

// File: tb/tb_acc_bias_unit.sv
// tb/tb_acc_bias_unit.sv - scoreboard bench for acc_bias_unit
module tb_acc_bias_unit;
  localparam int COLS = 5, PS_BW = 16, BI_BW = 8, AB0 = 25, AB1 = 18, ACC_LEN = 9;
  localparam int PW = PS_BW*COLS, BW = BI_BW*COLS, OW0 = AB0*COLS, OW1 = AB1*COLS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  acc_bias_unit_if #(.COLS(COLS), .PS_BW(PS_BW), .BI_BW(BI_BW), .AB_BW(AB0)) bus0 ();
  acc_bias_unit_if #(.COLS(COLS), .PS_BW(PS_BW), .BI_BW(BI_BW), .AB_BW(AB1)) bus1 ();

  acc_bias_unit #(.COLS(COLS), .PS_BW(PS_BW), .BI_BW(BI_BW), .AB_BW(AB0), .ACC_LEN(ACC_LEN))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  acc_bias_unit #(.COLS(COLS), .PS_BW(PS_BW), .BI_BW(BI_BW), .AB_BW(AB1), .ACC_LEN(ACC_LEN))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_cmp = 0, n_fail = 0, cyc = 0;
  logic [OW0-1:0] q0 [$];
  logic [OW1-1:0] q1 [$];
  int pulse_cyc [$];
  logic [OW0-1:0] e0;
  logic [OW1-1:0] e1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [OW0-1:0] pk0(input int a0, a1, a2, a3, a4);
    int v[5];
    v = '{a0, a1, a2, a3, a4};
    pk0 = '0;
    for (int c = 0; c < COLS; c++) pk0[(c+1)*AB0-1 -: AB0] = AB0'(v[c]);
  endfunction

  function automatic logic [OW1-1:0] pk1(input int a0, a1, a2, a3, a4);
    int v[5];
    v = '{a0, a1, a2, a3, a4};
    pk1 = '0;
    for (int c = 0; c < COLS; c++) pk1[(c+1)*AB1-1 -: AB1] = AB1'(v[c]);
  endfunction

  function automatic logic [PW-1:0] psv(input int p0, p1, p2, p3, p4);
    int v[5];
    v = '{p0, p1, p2, p3, p4};
    psv = '0;
    for (int c = 0; c < COLS; c++) psv[(c+1)*PS_BW-1 -: PS_BW] = PS_BW'(v[c]);
  endfunction

  function automatic logic [BW-1:0] bv(input int b);
    bv = '0;
    for (int c = 0; c < COLS; c++) bv[(c+1)*BI_BW-1 -: BI_BW] = BI_BW'(b);
  endfunction

  // One clock of stimulus, applied just after a rising edge.
  task automatic d0(input logic v, input logic [PW-1:0] ps, input logic clr,
                    input logic we, input logic [BW-1:0] b);
    bus0.i_valid = v; bus0.i_psum = ps; bus0.i_clear = clr;
    bus0.i_bias_we = we; bus0.i_bias = b;
    @(posedge clk); #1;
    bus0.i_valid = 1'b0; bus0.i_clear = 1'b0; bus0.i_bias_we = 1'b0;
  endtask

  task automatic d1(input logic v, input logic [PW-1:0] ps, input logic clr,
                    input logic we, input logic [BW-1:0] b);
    bus1.i_valid = v; bus1.i_psum = ps; bus1.i_clear = clr;
    bus1.i_bias_we = we; bus1.i_bias = b;
    @(posedge clk); #1;
    bus1.i_valid = 1'b0; bus1.i_clear = 1'b0; bus1.i_bias_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus0.o_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (q0.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut0 unexpected o_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e0 = q0.pop_front();
        check("dut0 result", 128'(bus0.o_acc_bias), 128'(e0));
      end
    end
    if (rst_n === 1'b1 && bus1.o_valid === 1'b1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dut1 unexpected o_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1 result", 128'(bus1.o_acc_bias), 128'(e1));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus0.i_valid = 0; bus0.i_psum = '0; bus0.i_clear = 0; bus0.i_bias_we = 0; bus0.i_bias = '0;
    bus1.i_valid = 0; bus1.i_psum = '0; bus1.i_clear = 0; bus1.i_bias_we = 0; bus1.i_bias = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset o_valid", 128'(bus0.o_valid), 128'(0));
    check("reset o_acc_bias", 128'(bus0.o_acc_bias), 128'(0));
    check("reset dut1 o_acc_bias", 128'(bus1.o_acc_bias), 128'(0));
    rst_n = 1'b1;

    // Basic: bias 10, mixed column values
    d0(0, '0, 0, 1, bv(10));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q0.push_back(pk0(910, -1790, 10, 10, 294913));
      d0(1, psv(100, -200, 0, 0, 32767), 0, 0, '0);
      if (i < 8) check("no early o_valid", 128'(bus0.o_valid), 128'(0));
    end
    check("latency o_valid", 128'(bus0.o_valid), 128'(1));
    d0(0, '0, 0, 0, '0);

    // Reset mid-group clears output immediately
    for (int i = 0; i < 3; i++) d0(1, psv(1, 1, 1, 1, 1), 0, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("async reset o_valid", 128'(bus0.o_valid), 128'(0));
    check("async reset o_acc_bias", 128'(bus0.o_acc_bias), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q0.push_back(pk0(9, 9, 9, 9, 9));
      d0(1, psv(1, 1, 1, 1, 1), 0, 0, '0);
    end

    // Gaps, then back-to-back groups
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q0.push_back(pk0(18, 18, 18, 18, 18));
      d0(1, psv(2, 2, 2, 2, 2), 0, 0, '0);
      if (i < 8) repeat ($urandom_range(0, 2)) d0(0, '0, 0, 0, '0);
    end
    for (int i = 0; i < 18; i++) begin
      if (i == 8 || i == 17) q0.push_back(pk0(9, 9, 9, 9, 9));
      d0(1, psv(1, 1, 1, 1, 1), 0, 0, '0);
    end
    repeat (2) d0(0, '0, 0, 0, '0);
    if (pulse_cyc.size() >= 2)
      check("back-to-back spacing", 128'(pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2]), 128'(9));
    else begin
      n_cmp++; n_fail++;
      $display("FAIL back-to-back pulses: got %0d expected >= 2", pulse_cyc.size());
    end

    // Clear discards partial group and a concurrent beat
    for (int i = 0; i < 4; i++) d0(1, psv(50, 50, 50, 50, 50), 0, 0, '0);
    d0(1, psv(50, 50, 50, 50, 50), 1, 0, '0);
    check("clear o_valid", 128'(bus0.o_valid), 128'(0));
    check("clear holds o_acc_bias", 128'(bus0.o_acc_bias), 128'(pk0(9, 9, 9, 9, 9)));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q0.push_back(pk0(9, 9, 9, 9, 9));
      d0(1, psv(1, 1, 1, 1, 1), 0, 0, '0);
    end

    // Bias load coincident with the final beat
    d0(0, '0, 0, 1, bv(5));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q0.push_back(pk0(14, 14, 14, 14, 14));
      d0(1, psv(1, 1, 1, 1, 1), 0, (i == 8), bv(-3));
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q0.push_back(pk0(6, 6, 6, 6, 6));
      d0(1, psv(1, 1, 1, 1, 1), 0, 0, '0);
    end

    // Saturation at AB_BW=18
    d1(0, '0, 0, 1, bv(127));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q1.push_back(pk1(131071, -130945, 9127, -8873, 127));
      d1(1, psv(32767, -32768, 1000, -1000, 0), 0, 0, '0);
    end
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q1.push_back(pk1(131071, 131071, 131071, 131071, 131071));
      d1(1, psv(32767, 32767, 32767, 32767, 32767), 0, 0, '0);
    end
    d1(0, '0, 0, 1, bv(-128));
    for (int i = 0; i < 9; i++) begin
      if (i == 8) q1.push_back(pk1(-131072, -131072, -131072, -131072, -131072));
      d1(1, psv(-32768, -32768, -32768, -32768, -32768), 0, 0, '0);
    end

    repeat (3) d0(0, '0, 0, 0, '0);
    check("dut0 scoreboard drained", 128'(q0.size()), 128'(0));
    check("dut1 scoreboard drained", 128'(q1.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
